// File: rtl/vpu_seq.sv
// vpu_seq: fetches a run of packed 64-bit VPU instructions, decodes each, issues it and waits for vpu done.
// Optional build macro VPU_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog that sets err and ends the run.
module vpu_seq #(
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned IMEM_LAT    = 2,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned OP_W        = 10,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [IMEM_AW-1:0] base_pc,
    input  logic [IMEM_AW-1:0] inst_count,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [63:0]        imem_rdata,
    output logic [OP_W-1:0]    vpu_opcode,
    output logic [ADDR_W-1:0]  vpu_addr_a,
    output logic [ADDR_W-1:0]  vpu_addr_b,
    output logic [ADDR_W-1:0]  vpu_addr_c,
    output logic [ADDR_W-1:0]  vpu_addr_const,
    output logic               vpu_start,
    input  logic               vpu_done,
    output logic               busy,
    output logic               seq_done,
    output logic               err
);

    localparam int unsigned A_LSB    = OP_W;
    localparam int unsigned B_LSB    = OP_W + ADDR_W;
    localparam int unsigned C_LSB    = OP_W + 2 * ADDR_W;
    localparam int unsigned K_LSB    = OP_W + 3 * ADDR_W;
    localparam int unsigned RSVD_LSB = OP_W + 4 * ADDR_W;
    localparam int unsigned LAT_W    = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [IMEM_AW-1:0] rem_q, rem_d;
    logic [LAT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [ADDR_W-1:0]  addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]  addr_b_q, addr_b_d;
    logic [ADDR_W-1:0]  addr_c_q, addr_c_d;
    logic [ADDR_W-1:0]  addr_k_q, addr_k_d;
    logic               imem_en_q, imem_en_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic               vpu_start_q, vpu_start_d;
    logic               busy_q, busy_d;
    logic               seq_done_q, seq_done_d;
    logic               err_q, err_d;

`ifdef VPU_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYC;
`endif

    // Reserved instruction bits carry no meaning.
    logic unused_rsvd;
    assign unused_rsvd = ^imem_rdata[63:RSVD_LSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            rd_cnt_q    <= '0;
            opcode_q    <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            addr_k_q    <= '0;
            imem_en_q   <= 1'b0;
            imem_addr_q <= '0;
            vpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rem_q       <= rem_d;
            rd_cnt_q    <= rd_cnt_d;
            opcode_q    <= opcode_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            addr_k_q    <= addr_k_d;
            imem_en_q   <= imem_en_d;
            imem_addr_q <= imem_addr_d;
            vpu_start_q <= vpu_start_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
        end
    end

`ifdef VPU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rem_d       = rem_q;
        rd_cnt_d    = rd_cnt_q;
        opcode_d    = opcode_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        addr_k_d    = addr_k_q;
        busy_d      = busy_q;
        err_d       = err_q;
        seq_done_d  = 1'b0;
        imem_en_d   = 1'b0;
        imem_addr_d = '0;
        vpu_start_d = 1'b0;
`ifdef VPU_SEQ_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    pc_d    = base_pc;
                    rem_d   = inst_count;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = (inst_count == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_cnt_d = '0;
                state_d  = S_WAIT_RD;
            end
            // Read data lands IMEM_LAT cycles after the enable cycle.
            S_WAIT_RD: begin
                if (rd_cnt_q == LAT_W'(IMEM_LAT - 1)) begin
                    opcode_d = imem_rdata[OP_W-1:0];
                    addr_a_d = imem_rdata[A_LSB +: ADDR_W];
                    addr_b_d = imem_rdata[B_LSB +: ADDR_W];
                    addr_c_d = imem_rdata[C_LSB +: ADDR_W];
                    addr_k_d = imem_rdata[K_LSB +: ADDR_W];
                    state_d  = S_ISSUE;
                end else begin
                    rd_cnt_d = rd_cnt_q + LAT_W'(1);
                end
            end
            S_ISSUE: begin
`ifdef VPU_SEQ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (vpu_done) begin
                    pc_d    = pc_q + IMEM_AW'(1);
                    rem_d   = rem_q - IMEM_AW'(1);
                    state_d = (rem_q == IMEM_AW'(1)) ? S_FINISH : S_FETCH;
                end
`ifdef VPU_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_FINISH: begin
                seq_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered so they coincide with the state they belong to.
        if (state_d == S_FETCH) begin
            imem_en_d   = 1'b1;
            imem_addr_d = pc_d;
        end
        if (state_d == S_ISSUE) begin
            vpu_start_d = 1'b1;
        end
    end

    assign imem_en        = imem_en_q;
    assign imem_addr      = imem_addr_q;
    assign vpu_opcode     = opcode_q;
    assign vpu_addr_a     = addr_a_q;
    assign vpu_addr_b     = addr_b_q;
    assign vpu_addr_c     = addr_c_q;
    assign vpu_addr_const = addr_k_q;
    assign vpu_start      = vpu_start_q;
    assign busy           = busy_q;
    assign seq_done       = seq_done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_vpu_seq.sv
// tb_vpu_seq: random and directed runs of vpu_seq against a BRAM model, a VPU responder and a scoreboard.
module tb_vpu_seq;

    localparam int unsigned IMEM_AW     = 8;
    localparam int unsigned IMEM_LAT    = 2;
    localparam int unsigned ADDR_W      = 13;
    localparam int unsigned OP_W        = 10;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned DEPTH       = 1 << IMEM_AW;

    typedef struct packed {
        logic [9:0]  op;
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] c;
        logic [12:0] k;
    } fld_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  base_pc;
    logic [7:0]  inst_count;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [63:0] imem_rdata;
    logic [9:0]  vpu_opcode;
    logic [12:0] vpu_addr_a;
    logic [12:0] vpu_addr_b;
    logic [12:0] vpu_addr_c;
    logic [12:0] vpu_addr_const;
    logic        vpu_start;
    logic        vpu_done;
    logic        busy;
    logic        seq_done;
    logic        err;

    vpu_seq #(
        .IMEM_AW(IMEM_AW), .IMEM_LAT(IMEM_LAT), .ADDR_W(ADDR_W),
        .OP_W(OP_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .base_pc(base_pc), .inst_count(inst_count),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .vpu_opcode(vpu_opcode), .vpu_addr_a(vpu_addr_a), .vpu_addr_b(vpu_addr_b),
        .vpu_addr_c(vpu_addr_c), .vpu_addr_const(vpu_addr_const),
        .vpu_start(vpu_start), .vpu_done(vpu_done), .busy(busy),
        .seq_done(seq_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference decode straight from the word layout.
    function automatic fld_t decode(input logic [63:0] w);
        fld_t f;
        f.op = 10'(w % 64'd1024);
        f.a  = 13'((w >> 10) % 64'd8192);
        f.b  = 13'((w >> 23) % 64'd8192);
        f.c  = 13'((w >> 36) % 64'd8192);
        f.k  = 13'((w >> 49) % 64'd8192);
        return f;
    endfunction

    fld_t dut_f;
    assign dut_f = {vpu_opcode, vpu_addr_a, vpu_addr_b, vpu_addr_c, vpu_addr_const};

    // Instruction BRAM: data appears IMEM_LAT cycles after the enable cycle, garbage otherwise.
    logic [63:0] mem    [DEPTH];
    logic [63:0] pipe_d [IMEM_LAT];
    logic        pipe_v [IMEM_LAT];
    always @(posedge clk) begin
        pipe_v[0] <= imem_en;
        pipe_d[0] <= mem[imem_addr];
        for (int i = 1; i < int'(IMEM_LAT); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign imem_rdata = pipe_v[IMEM_LAT-1] ? pipe_d[IMEM_LAT-1] : ~pipe_d[IMEM_LAT-1];

    logic [7:0] exp_addr_q[$];
    fld_t       exp_fld_q[$];
    logic       exp_fin_q[$];

    int     cur_delay;
    bit     hang;
    int     dly;
    bit     in_op;
    fld_t   cur;
    fld_t   last_start;
    int     n_fetch, n_start, n_fin;
    longint cyc, start_cyc, fin_cyc;

    // VPU responder plus scoreboard monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        vpu_done = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                vpu_done = 1'b1;
                if (in_op && !rst) check("fields_stable_at_done", dut_f, cur);
                in_op = 1'b0;
            end
        end
        if (rst) begin
            in_op = 1'b0;
        end else begin
            if (imem_en) begin
                n_fetch++;
                if (exp_addr_q.size() == 0) check("fetch_unexpected", 64'(imem_addr), 64'hFFFF);
                else check("imem_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (vpu_start) begin
                n_start++;
                start_cyc  = cyc;
                last_start = dut_f;
                if (exp_fld_q.size() == 0) begin
                    check("issue_unexpected", 64'd1, 64'd0);
                end else begin
                    cur = exp_fld_q.pop_front();
                    check("issue_fields", dut_f, cur);
                    in_op = 1'b1;
                end
                if (!hang) dly = cur_delay;
            end
            if (seq_done) begin
                n_fin++;
                fin_cyc = cyc;
                if (exp_fin_q.size() == 0) check("seq_done_unexpected", 64'd1, 64'd0);
                else check("seq_done_err", 64'(err), 64'(exp_fin_q.pop_front()));
            end
        end
    end

    task automatic run(input int base, input int count, input int delay, input bit to_exp, input bit noise);
        int  a;
        bit  done_ok;
        cur_delay = delay;
        if (to_exp) begin
            exp_addr_q.push_back(8'(base));
            exp_fld_q.push_back(decode(mem[base % DEPTH]));
            exp_fin_q.push_back(1'b1);
        end else begin
            for (int i = 0; i < count; i++) begin
                a = (base + i) % DEPTH;
                exp_addr_q.push_back(8'(a));
                exp_fld_q.push_back(decode(mem[a]));
            end
            exp_fin_q.push_back(1'b0);
        end
        @(negedge clk); #1;
        base_pc    = 8'(base);
        inst_count = 8'(count);
        go         = 1'b1;
        @(negedge clk); #1;
        go      = 1'b0;
        done_ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (exp_fin_q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
            go = noise && busy && ($urandom_range(0, 3) == 0);
            @(negedge clk); #1;
        end
        go = 1'b0;
        check("run_completes", 64'(done_ok), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("leftover_fetches", 64'(exp_addr_q.size()), 64'd0);
        check("leftover_issues", 64'(exp_fld_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int s_f, s_s, s_n, bad;
        bit started;
        rst = 1'b1; go = 1'b0; base_pc = '0; inst_count = '0;
        vpu_done = 1'b0; dly = 0; hang = 1'b0; in_op = 1'b0; cur_delay = 4;
        n_fetch = 0; n_start = 0; n_fin = 0; cyc = 0; start_cyc = 0; fin_cyc = 0;
        for (int i = 0; i < int'(IMEM_LAT); i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("rst_imem_en", 64'(imem_en), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_vpu_start", 64'(vpu_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_seq_done", 64'(seq_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_fields", dut_f, 64'd0);
        rst = 1'b0;

        // Three-instruction run from 4
        s_s = n_start; s_n = n_fin;
        run(4, 3, 6, 1'b0, 1'b0);
        check("t1_starts", 64'(n_start - s_s), 64'd3);
        check("t1_seq_done", 64'(n_fin - s_n), 64'd1);

        // Known word decode
        mem[10] = 64'h0000_0020_0080_0C05;
        run(10, 1, 3, 1'b0, 1'b0);
        check("t2_decode", last_start, {10'h005, 13'd3, 13'd1, 13'd2, 13'd0});

        // Empty run: busy one cycle, seq_done two cycles after go
        s_f = n_fetch; s_s = n_start;
        exp_fin_q.push_back(1'b0);
        @(negedge clk); #1;
        inst_count = 8'd0; base_pc = 8'h33; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        check("t3_busy_c1", 64'(busy), 64'd1);
        check("t3_done_c1", 64'(seq_done), 64'd0);
        @(negedge clk); #1;
        check("t3_busy_c2", 64'(busy), 64'd0);
        check("t3_done_c2", 64'(seq_done), 64'd1);
        @(negedge clk); #1;
        check("t3_done_c3", 64'(seq_done), 64'd0);
        check("t3_no_fetch", 64'(n_fetch - s_f), 64'd0);
        check("t3_no_start", 64'(n_start - s_s), 64'd0);

        // PC wrap
        run(255, 2, 2, 1'b0, 1'b0);

        // Random runs, half of them with stray go pulses mid-run
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) mem[$urandom_range(0, DEPTH - 1)] = {$urandom, $urandom};
            run($urandom_range(0, DEPTH - 1), $urandom_range(1, 5), $urandom_range(1, 8), 1'b0, r[0]);
        end

        // Reset in WAIT_DONE with a late done afterwards
        s_s = n_start;
        exp_addr_q.push_back(8'd20);
        exp_fld_q.push_back(decode(mem[20]));
        cur_delay = 10;
        @(negedge clk); #1;
        base_pc = 8'd20; inst_count = 8'd3; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        started = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (n_start != s_s) begin
                started = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("t5_started", 64'(started), 64'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        exp_addr_q.delete();
        exp_fld_q.delete();
        exp_fin_q.delete();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); #1;
            if (imem_en || vpu_start || busy || seq_done || err || (dut_f != '0)) bad++;
        end
        check("t5_quiet_after_rst", 64'(bad), 64'd0);
        check("t5_single_start", 64'(n_start - s_s), 64'd1);
        s_n = n_fin;
        run(40, 3, 5, 1'b0, 1'b1);
        check("t5_one_run", 64'(n_fin - s_n), 64'd1);

`ifdef VPU_SEQ_TIMEOUT_EN
        // Watchdog: no done ever returned
        hang = 1'b1;
        s_s  = n_start;
        run(60, 2, 1, 1'b1, 1'b0);
        hang = 1'b0;
        check("t6_one_start", 64'(n_start - s_s), 64'd1);
        check("t6_timeout_gap", 64'(fin_cyc - start_cyc), 64'(TIMEOUT_CYC + 2));
        check("t6_err_sticky", 64'(err), 64'd1);
        run(61, 1, 3, 1'b0, 1'b0);
        check("t6_err_cleared", 64'(err), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
